// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   ID-stage forwarding and load-use hazard control for the 5-stage MIPS pipeline.
//   Keeps a shadow scoreboard of the destination registers of the instructions now
//   in EX, MEM and WB. From it the unit computes the registered operand-A/B
//   selectors for the EX-stage mux3inputs forwarding muxes. It also raises a
//   one-cycle load-use stall and inserts a bubble into ID/EX.
//
//   Optional feature macro: HAZARD_STATS_EN (adds the saturating stall_count output).
//
// Ports
//   clk          pipeline clock, rising edge
//   rst_n        synchronous active-low reset
//   id_valid     ID holds a real instruction
//   id_rs/id_rt  source register fields of the ID instruction
//   id_uses_rs/id_uses_rt  ID instruction reads rs / rt
//   id_rd        destination register of the ID instruction
//   id_regwrite  ID instruction writes the register file
//   id_memread   ID instruction is a load
//   flush        taken branch/jump: kill the ID instruction
//   stall        hold PC and IF/ID (combinational)
//   fwd_a_sel    operand-A selector, registered, valid during EX
//                (0 regfile, 1 EX/MEM, 2 MEM/WB)
//   fwd_b_sel    operand-B selector, same timing and encoding
//   ex_valid/mem_valid/wb_valid  scoreboard slot occupancy
//   stall_count  saturating count of stall cycles (HAZARD_STATS_EN only)

module fwd_hazard_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   flush,
  output logic                   stall,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic                   ex_valid,
  output logic                   mem_valid,
`ifdef HAZARD_STATS_EN
  output logic                   wb_valid,
  output logic [STALL_CNT_W-1:0] stall_count
`else
  output logic                   wb_valid
`endif
);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_EX  = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;

  logic [REG_ADDR_W-1:0] ex_rd, mem_rd, wb_rd;
  logic                  ex_regwrite, mem_regwrite, wb_regwrite;
  logic                  ex_memread, mem_memread, wb_memread;

  logic                  ex_wr_rs, ex_wr_rt, mem_wr_rs, mem_wr_rt;
  logic                  load_hit;
  logic                  bubble;
  logic [1:0]            sel_a_nxt, sel_b_nxt;

  // Register 0 is hard-wired, so a slot never "writes" it.
  assign ex_wr_rs  = ex_valid  & ex_regwrite  & (ex_rd  == id_rs) & (id_rs != '0);
  assign ex_wr_rt  = ex_valid  & ex_regwrite  & (ex_rd  == id_rt) & (id_rt != '0);
  assign mem_wr_rs = mem_valid & mem_regwrite & (mem_rd == id_rs) & (id_rs != '0);
  assign mem_wr_rt = mem_valid & mem_regwrite & (mem_rd == id_rt) & (id_rt != '0);

  // A load in EX cannot feed the ID consumer in time; hold for one cycle so the
  // load reaches MEM and the consumer picks it up from MEM/WB instead.
  assign load_hit = ex_memread & ((id_uses_rs & ex_wr_rs) | (id_uses_rt & ex_wr_rt));
  assign stall    = id_valid & ~flush & load_hit;

  assign bubble = ~id_valid | flush | stall;

  // Youngest producer wins: EX slot is checked before MEM. The WB slot is never
  // forwarded because the register file writes before it is read in the same cycle.
  always_comb begin
    sel_a_nxt = SEL_RF;
    sel_b_nxt = SEL_RF;
    if (id_uses_rs) begin
      if (ex_wr_rs)       sel_a_nxt = SEL_EX;
      else if (mem_wr_rs) sel_a_nxt = SEL_MEM;
    end
    if (id_uses_rt) begin
      if (ex_wr_rt)       sel_b_nxt = SEL_EX;
      else if (mem_wr_rt) sel_b_nxt = SEL_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid     <= 1'b0;
      ex_rd        <= '0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      mem_valid    <= 1'b0;
      mem_rd       <= '0;
      mem_regwrite <= 1'b0;
      mem_memread  <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_regwrite  <= 1'b0;
      wb_memread   <= 1'b0;
      fwd_a_sel    <= SEL_RF;
      fwd_b_sel    <= SEL_RF;
    end else begin
      wb_valid     <= mem_valid;
      wb_rd        <= mem_rd;
      wb_regwrite  <= mem_regwrite;
      wb_memread   <= mem_memread;
      mem_valid    <= ex_valid;
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      mem_memread  <= ex_memread;
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_rd       <= '0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        fwd_a_sel   <= SEL_RF;
        fwd_b_sel   <= SEL_RF;
      end else begin
        ex_valid    <= 1'b1;
        ex_rd       <= id_rd;
        ex_regwrite <= id_regwrite;
        ex_memread  <= id_memread;
        fwd_a_sel   <= sel_a_nxt;
        fwd_b_sel   <= sel_b_nxt;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule
